conv_encoder_nk: RTL and testbench

CONV_ENCODER_NK -- requirements
Module: conv_encoder_nk

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_parity_nk.sv | 29 ++
 rtl/conv_encoder_nk.sv | 156 +++++++++++++++
 tb/tb_conv_encoder_nk.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and generator helpers
// for the rate-1/N convolutional encoder.
package conv_pkg;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } conv_st_e;

  localparam logic [11:0] CONV_G0_DEF = 12'o35;
  localparam logic [11:0] CONV_G1_DEF = 12'o23;
  localparam logic [23:0] CONV_G_DEF  = {CONV_G0_DEF, CONV_G1_DEF};

  // Octal digit p occupies mask bits 3p..3p+2; taps at or
  // above the constraint length are dropped.
  function automatic logic [11:0] oct2mask(
    input logic [11:0] g,
    input int          k
  );
    logic [11:0] m;
    m = '0;
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 3; b++) begin
        if (3 * p + b < k) begin
          m[3*p+b] = g[3*p+b];
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/conv_parity_nk.sv
// Combinational generator/parity datapath: one XOR tree
// per generator over {bit, state}, plus the state shift.
module conv_parity_nk
  import conv_pkg::*;
#(
  parameter int              K     = 5,
  parameter int              N     = 2,
  parameter logic [N*12-1:0] G_OCT = CONV_G_DEF
) (
  input  logic [K-2:0] state_i,
  input  logic         bit_i,
  output logic [N-1:0] sym_o,
  output logic [K-2:0] next_o
);

  logic [K-1:0] sr;

  assign sr = {bit_i, state_i};

  for (genvar j = 0; j < N; j++) begin : g_gen
    localparam logic [11:0] MW =
      oct2mask(G_OCT[(N-1-j)*12 +: 12], K);
    localparam logic [K-1:0] MK = MW[K-1:0];
    assign sym_o[N-1-j] = ^(sr & MK);
  end

  assign next_o = {bit_i, state_i[K-2:1]};

endmodule

// File: rtl/conv_encoder_nk.sv
// Rate-1/N convolutional encoder with valid/ready I/O,
// M-symbol zero tail and optional CONV_ENC_PUNCT_EN masks.
module conv_encoder_nk
  import conv_pkg::*;
#(
  parameter int                   K         = 5,
  parameter int                   N         = 2,
  parameter logic [N*12-1:0]      G_OCT     = CONV_G_DEF,
  parameter int                   PUNCT_P   = 2,
  parameter logic [PUNCT_P*N-1:0] PUNCT_PAT = {2'b11, 2'b10}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_load,
  input  logic [K-2:0] seed_value,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sym,
  output logic [N-1:0] out_mask,
  output logic         out_tail,
  output logic         out_last,
  output logic         busy
);

  localparam int M  = K - 1;
  localparam int TW = 4;

  if (K < 3 || K > 9 || N < 2 || N > 4 ||
      PUNCT_P < 1 || PUNCT_P > 8 ||
      $bits(PUNCT_PAT) != PUNCT_P * N) begin : g_bad_cfg
    $error("conv_encoder_nk: illegal parameters");
  end

  logic [M-1:0]  state_q;
  conv_st_e      fsm_q;
  logic [TW-1:0] tcnt_q;
  logic [N-1:0]  sym_q;
  logic [N-1:0]  mask_q;
  logic          valid_q;
  logic          tail_q;
  logic          last_q;

  logic          slot_free;
  logic          accept;
  logic          tail_fire;
  logic          tail_end;
  logic          produce;
  logic          par_bit;
  logic [N-1:0]  par_sym;
  logic [M-1:0]  par_next;
  logic [N-1:0]  mask_d;

  assign slot_free = !valid_q || out_ready;
  assign in_ready  = (fsm_q == ST_DATA) && !seed_load
                     && slot_free;
  assign accept    = in_valid && in_ready;
  assign tail_fire = (fsm_q == ST_TAIL) && slot_free;
  assign tail_end  = tail_fire && (tcnt_q == TW'(M - 1));
  assign produce   = accept || tail_fire;
  assign par_bit   = (fsm_q == ST_TAIL) ? 1'b0 : in_bit;

  conv_parity_nk #(
    .K     (K),
    .N     (N),
    .G_OCT (G_OCT)
  ) u_parity (
    .state_i (state_q),
    .bit_i   (par_bit),
    .sym_o   (par_sym),
    .next_o  (par_next)
  );

`ifdef CONV_ENC_PUNCT_EN
  logic [2:0] phase_q;

  assign mask_d =
    PUNCT_PAT[(PUNCT_P-1-int'(phase_q))*N +: N];

  // Puncture phase steps per symbol, restarts each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (tail_end) begin
      phase_q <= '0;
    end else if (produce) begin
      if (phase_q == 3'(PUNCT_P - 1)) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + 3'd1;
      end
    end
  end
`else
  assign mask_d = '1;
`endif

  // Frame control: DATA until in_last, then M tail slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= ST_DATA;
      tcnt_q <= '0;
    end else if (accept && in_last) begin
      fsm_q  <= ST_TAIL;
      tcnt_q <= '0;
    end else if (tail_end) begin
      fsm_q  <= ST_DATA;
      tcnt_q <= '0;
    end else if (tail_fire) begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end

  // Encoder state: shift on each symbol, seed only in DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (tail_end) begin
      state_q <= '0;
    end else if (produce) begin
      state_q <= par_next;
    end else if (fsm_q == ST_DATA && seed_load) begin
      state_q <= seed_value;
    end
  end

  // Output register: load on produce, drop after handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sym_q   <= '0;
      mask_q  <= '0;
      tail_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (produce) begin
      valid_q <= 1'b1;
      sym_q   <= par_sym;
      mask_q  <= mask_d;
      tail_q  <= tail_fire;
      last_q  <= tail_end;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_sym   = sym_q;
  assign out_mask  = mask_q;
  assign out_tail  = tail_q;
  assign out_last  = last_q;
  assign busy      = (fsm_q == ST_TAIL) || valid_q;

endmodule

// File: tb/tb_conv_encoder_nk.sv
// Directed bench for conv_encoder_nk (K=5, G 35/23).
// Honours CONV_ENC_PUNCT_EN for out_mask expectations.
module tb_conv_encoder_nk;

  logic       clk;
  logic       rst_n;
  logic       seed_load;
  logic [3:0] seed_value;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic [1:0] out_mask;
  logic       out_tail;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       b;
    logic       l;
    logic [1:0] s;
  } vec_t;

  typedef struct {
    logic [1:0] s;
    logic       t;
    logic       l;
  } exp_t;

  vec_t tbl[8];
  logic [1:0] tail_exp[4];
  exp_t q[$];

  conv_encoder_nk dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed_value (seed_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bit     (in_bit),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sym    (out_sym),
    .out_mask   (out_mask),
    .out_tail   (out_tail),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [1:0] msym(
    input logic [3:0] st, input logic b);
    logic [4:0] r;
    r = {b, st};
    return {^(r & 5'b11101), ^(r & 5'b10011)};
  endfunction

  function automatic logic [1:0] emask(input int idx);
`ifdef CONV_ENC_PUNCT_EN
    return (idx % 2 == 0) ? 2'b11 : 2'b10;
`else
    return 2'b11;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic l);
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_bit    = 1'b0;
    seed_load = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [3:0] mst;
    logic [1:0] s;
    logic       rb;
    exp_t       e;
    int         sent;
    int         got;
    int         tails;
    int         lasts;
    int         cyc;

    tbl[0] = '{1'b1, 1'b0, 2'b11};
    tbl[1] = '{1'b0, 1'b0, 2'b10};
    tbl[2] = '{1'b1, 1'b0, 2'b01};
    tbl[3] = '{1'b1, 1'b0, 2'b00};
    tbl[4] = '{1'b0, 1'b0, 2'b11};
    tbl[5] = '{1'b0, 1'b0, 2'b11};
    tbl[6] = '{1'b1, 1'b0, 2'b01};
    tbl[7] = '{1'b0, 1'b1, 2'b01};
    tail_exp[0] = 2'b10;
    tail_exp[1] = 2'b01;
    tail_exp[2] = 2'b11;
    tail_exp[3] = 2'b00;

    seed_value = 4'b0000;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    in_last    = 1'b0;
    seed_load  = 1'b0;
    out_ready  = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sym", 32'(out_sym), 0);
    chk("rst_out_mask", 32'(out_mask), 0);
    chk("rst_out_tail", 32'(out_tail), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 1);

    // Table frame, tail with ignored seed_load
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].b, tbl[i].l);
      chk($sformatf("tbl_valid_%0d", i),
          32'(out_valid), 1);
      chk($sformatf("tbl_sym_%0d", i),
          32'(out_sym), 32'(tbl[i].s));
      chk($sformatf("tbl_mask_%0d", i),
          32'(out_mask), 32'(emask(i)));
      chk($sformatf("tbl_tail_%0d", i),
          32'(out_tail), 0);
      chk($sformatf("tbl_rdy_%0d", i),
          32'(in_ready), 32'(!tbl[i].l));
    end
    seed_load  = 1'b1;
    seed_value = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      step();
      chk($sformatf("tail_sym_%0d", t),
          32'(out_sym), 32'(tail_exp[t]));
      chk($sformatf("tail_flag_%0d", t),
          32'(out_tail), 1);
      chk($sformatf("tail_last_%0d", t),
          32'(out_last), 32'(t == 3));
      chk($sformatf("tail_mask_%0d", t),
          32'(out_mask), 32'(emask(8 + t)));
      if (t == 2) seed_load = 1'b0;
    end
    step();
    chk("post_tail_valid", 32'(out_valid), 0);
    chk("post_tail_busy", 32'(busy), 0);
    chk("post_tail_rdy", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].b, 1'b0);
      chk($sformatf("restart_sym_%0d", i),
          32'(out_sym), 32'(tbl[i].s));
      chk($sformatf("restart_mask_%0d", i),
          32'(out_mask), 32'(emask(i)));
    end

    // Backpressure hold for 5 cycles
    do_reset();
    send(1'b1, 1'b0);
    chk("bp_first", 32'(out_sym), 2'b11);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b0;
    #1;
    chk("bp_rdy_drop", 32'(in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold_sym_%0d", i),
          32'(out_sym), 2'b11);
      chk($sformatf("bp_hold_vld_%0d", i),
          32'(out_valid), 1);
      chk($sformatf("bp_hold_rdy_%0d", i),
          32'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_next_sym", 32'(out_sym), 2'b10);
    chk("bp_next_vld", 32'(out_valid), 1);
    step();
    chk("bp_drain", 32'(out_valid), 0);

    // Seed load then two bits
    do_reset();
    seed_value = 4'b1010;
    seed_load  = 1'b1;
    #1;
    chk("seed_rdy", 32'(in_ready), 0);
    step();
    seed_load = 1'b0;
    chk("seed_no_sym", 32'(out_valid), 0);
    send(1'b0, 1'b0);
    chk("seed_sym0", 32'(out_sym), 2'b11);
    chk("seed_model0", 32'(out_sym),
        32'(msym(4'b1010, 1'b0)));
    send(1'b1, 1'b0);
    chk("seed_model1", 32'(out_sym),
        32'(msym(4'b0101, 1'b1)));

    // 100-bit random frame with random backpressure
    do_reset();
    mst   = 4'b0000;
    sent  = 0;
    got   = 0;
    tails = 0;
    lasts = 0;
    cyc   = 0;
    q.delete();
    while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_extra_sym", 32'(out_valid), 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("rand_sym_%0d", got),
              32'(out_sym), 32'(e.s));
          chk($sformatf("rand_tail_%0d", got),
              32'(out_tail), 32'(e.t));
          chk($sformatf("rand_last_%0d", got),
              32'(out_last), 32'(e.l));
          chk($sformatf("rand_mask_%0d", got),
              32'(out_mask), 32'(emask(got)));
        end
        if (out_tail) tails++;
        if (out_last) lasts++;
        got++;
      end
      if (in_ready && sent < 100) begin
        rb       = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        in_bit   = rb;
        in_last  = (sent == 99);
        q.push_back('{msym(mst, rb), 1'b0, 1'b0});
        mst = {rb, mst[3:1]};
        if (sent == 99) begin
          for (int t = 0; t < 4; t++) begin
            s = msym(mst, 1'b0);
            q.push_back('{s, 1'b1, 1'(t == 3)});
            mst = {1'b0, mst[3:1]};
          end
        end
        sent++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("rand_timeout", 32'(cyc < 3000), 1);
    chk("rand_count", 32'(got), 104);
    chk("rand_tails", 32'(tails), 4);
    chk("rand_lasts", 32'(lasts), 1);
    #1;
    chk("rand_idle_vld", 32'(out_valid), 0);
    chk("rand_idle_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].b, 1'b0);
      chk($sformatf("rand_zero_%0d", i),
          32'(out_sym), 32'(tbl[i].s));
    end

    // Reset pulse during TAIL
    do_reset();
    send(1'b1, 1'b1);
    chk("rt_data_sym", 32'(out_sym), 2'b11);
    step();
    chk("rt_tail_sym", 32'(out_sym), 2'b10);
    chk("rt_tail_flag", 32'(out_tail), 1);
    rst_n = 1'b0;
    #1;
    chk("rt_vld_drop", 32'(out_valid), 0);
    chk("rt_busy_drop", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rt_rdy", 32'(in_ready), 1);
    chk("rt_idle", 32'(out_valid), 0);
    send(1'b1, 1'b0);
    chk("rt_new0", 32'(out_sym), 2'b11);
    chk("rt_new0_mask", 32'(out_mask), 32'(emask(0)));
    send(1'b0, 1'b0);
    chk("rt_new1", 32'(out_sym), 2'b10);
    chk("rt_new1_tail", 32'(out_tail), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
